mem_req_scheduler: RTL and testbench

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_req_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
// -----------------------------------------------------------------------------
// mem_req_scheduler
//
// Accepts read/write requests from a single client and issues them to a
// memory controller.
// - Writes are buffered in WQ (address + data) and reads in RQ (address).
// - Each direction issues in order and is limited to MAX_OUT in-flight
//   requests.
// - A read whose address matches any write still waiting in WQ is held back
//   (read-after-write), so the read always observes the newer data.
// - Read returns are forwarded to the client as registered one-cycle responses.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             client request handshake (ready is comb.)
//   req_write/req_address/req_data  request type, address and write data
//   wr_en/wr_address/wr_data        write issue pulse and payload
//   wr_ret_ack                      write completion from the controller
//   rd_en/rd_address                read issue pulse and address
//   rd_ret_ack/rd_ret_address/rd_ret_data  read return from the controller
//   resp_valid/resp_address/resp_data      read response to the client
// -----------------------------------------------------------------------------
module mem_req_scheduler #(
  parameter int QDEPTH  = 4,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  output logic        wr_en,
  output logic [15:0] wr_address,
  output logic [15:0] wr_data,
  input  logic        wr_ret_ack,
  output logic        rd_en,
  output logic [15:0] rd_address,
  input  logic        rd_ret_ack,
  input  logic [15:0] rd_ret_address,
  input  logic [15:0] rd_ret_data,
  output logic        resp_valid,
  output logic [15:0] resp_address,
  output logic [15:0] resp_data
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL     = CW'(QDEPTH);
  localparam logic [3:0]    MAX_OUT_C = 4'(MAX_OUT);

  // Queue storage and bookkeeping
  logic [15:0]   wq_addr_q [QDEPTH];
  logic [15:0]   wq_data_q [QDEPTH];
  logic [15:0]   rq_addr_q [QDEPTH];
  logic [PW-1:0] wq_wr_ptr_q, wq_rd_ptr_q;
  logic [PW-1:0] rq_wr_ptr_q, rq_rd_ptr_q;
  logic [CW-1:0] wq_cnt_q, wq_cnt_d;
  logic [CW-1:0] rq_cnt_q, rq_cnt_d;

  // In-flight counters
  logic [3:0]    wr_out_q, wr_out_d;
  logic [3:0]    rd_out_q, rd_out_d;

  // Registered outputs
  logic          wr_en_q, rd_en_q, resp_valid_q;
  logic [15:0]   wr_address_q, wr_data_q, rd_address_q;
  logic [15:0]   resp_address_q, resp_data_q;

  // Combinational control
  logic          wq_full_s, rq_full_s;
  logic          wq_push_s, rq_push_s;
  logic          wr_issue_s, rd_issue_s;
  logic          raw_hit_s;

  assign wr_en        = wr_en_q;
  assign wr_address   = wr_address_q;
  assign wr_data      = wr_data_q;
  assign rd_en        = rd_en_q;
  assign rd_address   = rd_address_q;
  assign resp_valid   = resp_valid_q;
  assign resp_address = resp_address_q;
  assign resp_data    = resp_data_q;

  // Handshake, push/issue decisions and the read-after-write address check
  always_comb begin
    wq_full_s = (wq_cnt_q == QFULL);
    rq_full_s = (rq_cnt_q == QFULL);

    if (req_write) begin
      req_ready = !wq_full_s;
    end else begin
      req_ready = !rq_full_s;
    end

    wq_push_s = req_valid & req_write & !wq_full_s;
    rq_push_s = req_valid & !req_write & !rq_full_s;

    // A slot is live when its distance from the read pointer is below the
    // occupancy; a full queue makes every slot live (low count bits wrap to 0).
    raw_hit_s = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      raw_hit_s = raw_hit_s |
                  ((wq_full_s || ((PW'(i) - wq_rd_ptr_q) < wq_cnt_q[PW-1:0])) &&
                   (wq_addr_q[i] == rq_addr_q[rq_rd_ptr_q]));
    end

    wr_issue_s = (wq_cnt_q != '0) && (wr_out_q < MAX_OUT_C);
    rd_issue_s = (rq_cnt_q != '0) && (rd_out_q < MAX_OUT_C) && !raw_hit_s;
  end

  // Next-state occupancy and in-flight counters
  always_comb begin
    if (wq_push_s && !wr_issue_s) begin
      wq_cnt_d = wq_cnt_q + CW'(1'b1);
    end else if (!wq_push_s && wr_issue_s) begin
      wq_cnt_d = wq_cnt_q - CW'(1'b1);
    end else begin
      wq_cnt_d = wq_cnt_q;
    end

    if (rq_push_s && !rd_issue_s) begin
      rq_cnt_d = rq_cnt_q + CW'(1'b1);
    end else if (!rq_push_s && rd_issue_s) begin
      rq_cnt_d = rq_cnt_q - CW'(1'b1);
    end else begin
      rq_cnt_d = rq_cnt_q;
    end

    // Acks with nothing outstanding (e.g. after a reset) saturate at zero.
    if (wr_issue_s && !wr_ret_ack) begin
      wr_out_d = wr_out_q + 4'd1;
    end else if (!wr_issue_s && wr_ret_ack && (wr_out_q != 4'd0)) begin
      wr_out_d = wr_out_q - 4'd1;
    end else begin
      wr_out_d = wr_out_q;
    end

    if (rd_issue_s && !rd_ret_ack) begin
      rd_out_d = rd_out_q + 4'd1;
    end else if (!rd_issue_s && rd_ret_ack && (rd_out_q != 4'd0)) begin
      rd_out_d = rd_out_q - 4'd1;
    end else begin
      rd_out_d = rd_out_q;
    end
  end

  // All sequential state: queues, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        wq_addr_q[i] <= 16'h0000;
        wq_data_q[i] <= 16'h0000;
        rq_addr_q[i] <= 16'h0000;
      end
      wq_wr_ptr_q    <= '0;
      wq_rd_ptr_q    <= '0;
      rq_wr_ptr_q    <= '0;
      rq_rd_ptr_q    <= '0;
      wq_cnt_q       <= '0;
      rq_cnt_q       <= '0;
      wr_out_q       <= 4'd0;
      rd_out_q       <= 4'd0;
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      wr_address_q   <= 16'h0000;
      wr_data_q      <= 16'h0000;
      rd_address_q   <= 16'h0000;
      resp_address_q <= 16'h0000;
      resp_data_q    <= 16'h0000;
    end else begin
      wq_cnt_q <= wq_cnt_d;
      rq_cnt_q <= rq_cnt_d;
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;

      if (wq_push_s) begin
        wq_addr_q[wq_wr_ptr_q] <= req_address;
        wq_data_q[wq_wr_ptr_q] <= req_data;
        wq_wr_ptr_q            <= wq_wr_ptr_q + PW'(1'b1);
      end else begin
        wq_wr_ptr_q <= wq_wr_ptr_q;
      end

      if (rq_push_s) begin
        rq_addr_q[rq_wr_ptr_q] <= req_address;
        rq_wr_ptr_q            <= rq_wr_ptr_q + PW'(1'b1);
      end else begin
        rq_wr_ptr_q <= rq_wr_ptr_q;
      end

      wr_en_q <= wr_issue_s;
      if (wr_issue_s) begin
        wr_address_q <= wq_addr_q[wq_rd_ptr_q];
        wr_data_q    <= wq_data_q[wq_rd_ptr_q];
        wq_rd_ptr_q  <= wq_rd_ptr_q + PW'(1'b1);
      end else begin
        wr_address_q <= wr_address_q;
        wr_data_q    <= wr_data_q;
        wq_rd_ptr_q  <= wq_rd_ptr_q;
      end

      rd_en_q <= rd_issue_s;
      if (rd_issue_s) begin
        rd_address_q <= rq_addr_q[rq_rd_ptr_q];
        rq_rd_ptr_q  <= rq_rd_ptr_q + PW'(1'b1);
      end else begin
        rd_address_q <= rd_address_q;
        rq_rd_ptr_q  <= rq_rd_ptr_q;
      end

      resp_valid_q <= rd_ret_ack;
      if (rd_ret_ack) begin
        resp_address_q <= rd_ret_address;
        resp_data_q    <= rd_ret_data;
      end else begin
        resp_address_q <= resp_address_q;
        resp_data_q    <= resp_data_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mem_req_scheduler
//
// Scoreboard bench. The stimulus side keeps a queue-based reference model of
// the scheduler (request queues as SV queues, in-flight counts as ints) and,
// for every cycle, pushes the expected issue/response events tagged with the
// clock edge on which they must appear. An independent monitor process checks
// the DUT after each rising edge against those expectations.
// -----------------------------------------------------------------------------
module tb_mem_req_scheduler;

  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 4;

  typedef struct {
    int          e;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_address = 16'h0000;
  logic [15:0] req_data = 16'h0000;
  logic        wr_en;
  logic [15:0] wr_address, wr_data;
  logic        wr_ret_ack = 1'b0;
  logic        rd_en;
  logic [15:0] rd_address;
  logic        rd_ret_ack = 1'b0;
  logic [15:0] rd_ret_address = 16'h0000;
  logic [15:0] rd_ret_data = 16'h0000;
  logic        resp_valid;
  logic [15:0] resp_address, resp_data;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  // Reference model state
  logic [31:0] m_wq[$];
  logic [15:0] m_rq[$];
  int          m_wr_out = 0;
  int          m_rd_out = 0;

  // Expected events, tagged with their edge number
  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t exp_resp[$];
  logic [15:0] last_wa = 16'h0, last_wd = 16'h0, last_ra = 16'h0;
  logic [15:0] last_pa = 16'h0, last_pd = 16'h0;

  mem_req_scheduler #(.QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .wr_ret_ack(wr_ret_ack),
    .rd_en(rd_en), .rd_address(rd_address),
    .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data),
    .resp_valid(resp_valid), .resp_address(resp_address), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  // One cycle of stimulus: drive inputs at the falling edge, check ready,
  // then advance the reference model across the coming rising edge.
  task automatic drive(input bit v, input bit w, input logic [15:0] a, input logic [15:0] dat,
                       input bit wack, input bit rack, input logic [15:0] ra,
                       input logic [15:0] rdat, output bit acc);
    bit          mready, wi, ri, hit;
    logic [31:0] x;
    logic [15:0] y;
    @(negedge clk);
    rst_n          = 1'b1;
    req_valid      = v;
    req_write      = w;
    req_address    = a;
    req_data       = dat;
    wr_ret_ack     = wack;
    rd_ret_ack     = rack;
    rd_ret_address = ra;
    rd_ret_data    = rdat;
    #1;
    mready = w ? (m_wq.size() < QDEPTH) : (m_rq.size() < QDEPTH);
    checks++;
    if (req_ready !== mready) begin
      errors++;
      $display("FAIL req_ready edge %0d: got %b want %b", ecount + 1, req_ready, mready);
    end
    acc = v && mready;
    wi  = (m_wq.size() > 0) && (m_wr_out < MAX_OUT);
    hit = 1'b0;
    if (m_rq.size() > 0) begin
      foreach (m_wq[k]) if (m_wq[k][31:16] == m_rq[0]) hit = 1'b1;
    end
    ri = (m_rq.size() > 0) && (m_rd_out < MAX_OUT) && !hit;
    if (wi) begin
      x = m_wq.pop_front();
      exp_wr.push_back('{ecount + 1, x[31:16], x[15:0]});
    end
    if (ri) begin
      y = m_rq.pop_front();
      exp_rd.push_back('{ecount + 1, y, 16'h0000});
    end
    if (acc && w) m_wq.push_back({a, dat});
    else if (acc) m_rq.push_back(a);
    if (wi && !wack) m_wr_out++;
    else if (!wi && wack && m_wr_out > 0) m_wr_out--;
    if (ri && !rack) m_rd_out++;
    else if (!ri && rack && m_rd_out > 0) m_rd_out--;
    if (rack) exp_resp.push_back('{ecount + 1, ra, rdat});
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, acc);
  endtask

  // Present a request until accepted (bounded).
  task automatic send(input bit w, input logic [15:0] a, input logic [15:0] dat);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      drive(1'b1, w, a, dat, 1'b0, 1'b0, 16'h0, 16'h0, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %h not accepted within 40 cycles", a);
    end
  endtask

  task automatic acks(input int n, input bit wack, input bit rack);
    bit acc;
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 16'h0, 16'h0, wack, rack, 16'($urandom), 16'($urandom), acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    wr_ret_ack = 1'b0;
    rd_ret_ack = 1'b0;
    #1;
    m_wq.delete(); m_rq.delete();
    exp_wr.delete(); exp_rd.delete(); exp_resp.delete();
    m_wr_out = 0; m_rd_out = 0;
    last_wa = 16'h0; last_wd = 16'h0; last_ra = 16'h0; last_pa = 16'h0; last_pd = 16'h0;
    checks++;
    if ({wr_en, rd_en, resp_valid, wr_address, wr_data, rd_address, resp_address, resp_data} !== 99'd0) begin
      errors++;
      $display("FAIL async_reset: outputs en=%b%b%b wa=%h wd=%h ra=%h pa=%h pd=%h want all 0",
               wr_en, rd_en, resp_valid, wr_address, wr_data, rd_address, resp_address, resp_data);
    end
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs after every rising edge.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_wr.size() > 0 && exp_wr[0].e == ecount) begin
        ev = exp_wr.pop_front();
        last_wa = ev.a; last_wd = ev.d;
        if (wr_en !== 1'b1 || wr_address !== ev.a || wr_data !== ev.d) begin
          errors++;
          $display("FAIL wr_issue edge %0d: got en=%b a=%h d=%h want en=1 a=%h d=%h",
                   ecount, wr_en, wr_address, wr_data, ev.a, ev.d);
        end
      end else if (wr_en !== 1'b0 || wr_address !== last_wa || wr_data !== last_wd) begin
        errors++;
        $display("FAIL wr_idle edge %0d: got en=%b a=%h d=%h want en=0 a=%h d=%h",
                 ecount, wr_en, wr_address, wr_data, last_wa, last_wd);
      end
      checks++;
      if (exp_rd.size() > 0 && exp_rd[0].e == ecount) begin
        ev = exp_rd.pop_front();
        last_ra = ev.a;
        if (rd_en !== 1'b1 || rd_address !== ev.a) begin
          errors++;
          $display("FAIL rd_issue edge %0d: got en=%b a=%h want en=1 a=%h", ecount, rd_en, rd_address, ev.a);
        end
      end else if (rd_en !== 1'b0 || rd_address !== last_ra) begin
        errors++;
        $display("FAIL rd_idle edge %0d: got en=%b a=%h want en=0 a=%h", ecount, rd_en, rd_address, last_ra);
      end
      checks++;
      if (exp_resp.size() > 0 && exp_resp[0].e == ecount) begin
        ev = exp_resp.pop_front();
        last_pa = ev.a; last_pd = ev.d;
        if (resp_valid !== 1'b1 || resp_address !== ev.a || resp_data !== ev.d) begin
          errors++;
          $display("FAIL resp edge %0d: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                   ecount, resp_valid, resp_address, resp_data, ev.a, ev.d);
        end
      end else if (resp_valid !== 1'b0 || resp_address !== last_pa || resp_data !== last_pd) begin
        errors++;
        $display("FAIL resp_idle edge %0d: got v=%b a=%h d=%h want v=0 a=%h d=%h",
                 ecount, resp_valid, resp_address, resp_data, last_pa, last_pd);
      end
      checks++;
      if (dut.wr_out_q !== 4'(m_wr_out) || dut.rd_out_q !== 4'(m_rd_out)) begin
        errors++;
        $display("FAIL out_counters edge %0d: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                 ecount, dut.wr_out_q, dut.rd_out_q, m_wr_out, m_rd_out);
      end
      checks++;
      if (int'(dut.wq_cnt_q) != m_wq.size() || int'(dut.rq_cnt_q) != m_rq.size()) begin
        errors++;
        $display("FAIL occupancy edge %0d: got wq=%0d rq=%0d want wq=%0d rq=%0d",
                 ecount, dut.wq_cnt_q, dut.rq_cnt_q, m_wq.size(), m_rq.size());
      end
    end
  end

  // Stimulus
  initial begin
    bit acc;
    #1;
    checks++;
    if ({wr_en, rd_en, resp_valid, wr_address, wr_data, rd_address, resp_address, resp_data} !== 99'd0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero");
    end

    // Single write into an empty block, acks held low
    send(1'b1, 16'h0096, 16'h0001);
    idle(3);
    acks(1, 1'b1, 1'b0);

    // Five reads, no acks: the fifth waits for a read return
    for (int i = 1; i <= 5; i++) send(1'b0, 16'(i), 16'h0);
    idle(3);
    acks(1, 1'b0, 1'b1);
    idle(2);
    acks(5, 1'b0, 1'b1);

    // Read-after-write stall behind writes blocked by the in-flight limit
    for (int i = 0; i < MAX_OUT; i++) send(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    send(1'b1, 16'h0020, 16'h1111);
    send(1'b1, 16'h0010, 16'h2222);
    send(1'b0, 16'h0011, 16'h0);
    send(1'b0, 16'h0010, 16'h0);
    idle(4);
    acks(1, 1'b1, 1'b0);
    idle(1);
    acks(1, 1'b1, 1'b0);
    idle(3);
    acks(6, 1'b1, 1'b1);

    // Read return forwarded as a response
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0096, 16'hBEEF, acc);
    idle(2);

    // Simultaneous write/read issue; ack and issue in the same cycle
    for (int i = 0; i < MAX_OUT; i++) begin
      send(1'b1, 16'h0200 + 16'(i), 16'hB000 + 16'(i));
      send(1'b0, 16'h0300 + 16'(i), 16'h0);
    end
    send(1'b1, 16'h0210, 16'hC000);
    send(1'b1, 16'h0211, 16'hC001);
    send(1'b0, 16'h0310, 16'h0);
    send(1'b0, 16'h0311, 16'h0);
    idle(2);
    acks(2, 1'b1, 1'b1);
    idle(2);
    acks(8, 1'b1, 1'b1);
    idle(2);

    // Reset with three queued requests
    for (int i = 0; i < MAX_OUT; i++) send(1'b1, 16'h0400 + 16'(i), 16'hD000 + 16'(i));
    send(1'b1, 16'h0500, 16'h0001);
    send(1'b1, 16'h0501, 16'h0002);
    send(1'b1, 16'h0502, 16'h0003);
    idle(1);
    do_reset();
    idle(4);
    acks(1, 1'b1, 1'b1);
    idle(2);

    // Randomized traffic over a small address set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
            16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            16'($urandom), 16'($urandom), acc);
    end
    acks(14, 1'b1, 1'b1);
    idle(3);

    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_resp.size() != 0 ||
        m_wq.size() != 0 || m_rq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending wr=%0d rd=%0d resp=%0d wq=%0d rq=%0d want all 0",
               exp_wr.size(), exp_rd.size(), exp_resp.size(), m_wq.size(), m_rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
